// File: rtl/sram_requester.sv
`default_nettype none
// sram_requester: bridges MEM-stage loads/stores onto a single-port SRAM controller
// through a one-entry posted write buffer, with optional store-to-load forwarding.
module sram_requester #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        freeze,
  output logic        read_en,
  output logic        write_en,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  input  logic        ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        read_en_q, write_en_q;
  logic [31:0] address_q, write_data_q;

  logic hit, accept, drain_done, rd_done;

  assign hit        = (FWD_EN == 1'b1) && wb_valid_q && (wb_addr_q[31:2] == mem_address[31:2]);
  assign drain_done = (state_q == DRAIN) && ready;
  assign rd_done    = (state_q == READ) && ready;
  // A store may slip into the buffer in the very cycle the previous one retires.
  assign accept     = mem_w_en && !mem_r_en && (!wb_valid_q || drain_done);

  always_comb begin
    state_d    = state_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (wb_valid_q)               state_d = DRAIN;
        else if (mem_r_en && !hit)    state_d = READ;
      end
      DRAIN: begin
        if (ready) begin
          state_d    = IDLE;
          wb_valid_d = 1'b0;
        end
      end
      READ: begin
        if (ready) begin
          state_d = IDLE;
          rdata_d = read_data;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = mem_address;
      wb_data_d  = mem_write_data;
    end
  end

  always_comb begin
    freeze = 1'b0;
    if (!rst)          freeze = 1'b0;
    else if (mem_r_en) freeze = !hit && !rd_done;
    else if (mem_w_en) freeze = !accept;
  end

  always_comb begin
    mem_read_data = rdata_q;
    if (mem_r_en && hit)          mem_read_data = wb_data_q;
    else if (mem_r_en && rd_done) mem_read_data = read_data;
  end

  // Controller-side outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      rdata_q      <= '0;
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      rdata_q      <= rdata_d;
      read_en_q    <= (state_d == READ);
      write_en_q   <= (state_d == DRAIN);
      address_q    <= (state_d == READ)  ? mem_address :
                      (state_d == DRAIN) ? wb_addr_d   : '0;
      write_data_q <= (state_d == DRAIN) ? wb_data_d : '0;
    end
  end

  assign read_en    = read_en_q;
  assign write_en   = write_en_q;
  assign address    = address_q;
  assign write_data = write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_requester.sv
`default_nettype none
// tb_sram_requester: memory-consistency reference model plus directed timing checks
// against a variable-latency SRAM controller model.
module tb_sram_requester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_r_en, mem_w_en;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        freeze, read_en, write_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_requester #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst_n),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .freeze(freeze),
    .read_en(read_en), .write_en(write_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready)
  );

  // Controller backing store and the pipeline-visible reference memory (word addressed).
  logic [31:0] ctrl_mem [logic [29:0]];
  logic [31:0] ref_mem  [logic [29:0]];

  function automatic logic [31:0] def_word(input logic [29:0] wa);
    return {wa[15:0] ^ 16'hA5C3, wa[15:0]};
  endfunction

  function automatic logic [31:0] ctrl_word(input logic [29:0] wa);
    return ctrl_mem.exists(wa) ? ctrl_mem[wa] : def_word(wa);
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : def_word(wa);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Controller: ready rises after cur_lat low cycles of a request.
  int cnt, cur_lat, next_lat;
  assign ready = (read_en || write_en) && (cnt >= cur_lat);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 0;
      cur_lat <= next_lat;
    end else if (!(read_en || write_en) || ready) begin
      cnt     <= 0;
      cur_lat <= next_lat;
    end else begin
      cnt <= cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && write_en && ready) ctrl_mem[address[31:2]] = write_data;
  end

  always @(posedge clk) begin
    #2;
    read_data = read_en ? ctrl_word(address[31:2]) : $urandom;
  end

  // Compare process: every completed load must see the latest accepted store.
  always @(negedge clk) begin
    if (rst_n) begin
      check("no_overlap", {31'b0, read_en && write_en}, 32'd0);
      if (read_en) begin
        check("read_has_load", {31'b0, mem_r_en}, 32'd1);
        check("read_addr", address, mem_address);
      end
      if (mem_r_en && !freeze)
        check("load_data", mem_read_data, ref_word(mem_address[31:2]));
      else if (mem_w_en && !freeze)
        ref_mem[mem_address[31:2]] = mem_write_data;
    end
  end

  task automatic do_instr(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int stalls, output logic [31:0] rdat);
    mem_r_en = r; mem_w_en = w; mem_address = a; mem_write_data = d;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!freeze) break;
      stalls++;
      if (stalls > 60) begin
        total++; bad++;
        $display("FAIL stall_timeout: frozen %0d cycles, expected release", stalls);
        break;
      end
      @(posedge clk); #1;
    end
    rdat = mem_read_data;
    @(posedge clk); #1;
  endtask

  task automatic go_idle(input int n);
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int st, n;
    logic [31:0] rd;
    logic [29:0] wa;
    logic [31:0] a;

    rst_n = 1'b0; next_lat = 5; read_data = '0;
    mem_r_en = 1'b1; mem_w_en = 1'b0; mem_address = 32'h500; mem_write_data = '0;
    wa = 30'h140; ctrl_mem[wa] = 32'hCAFEF00D; ref_mem[wa] = 32'hCAFEF00D;
    wa = 30'h1C0; ctrl_mem[wa] = 32'h70707070; ref_mem[wa] = 32'h70707070;

    // Reset with a pending load request
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_freeze", {31'b0, freeze}, 32'd0);
    check("rst_read_en", {31'b0, read_en}, 32'd0);
    check("rst_write_en", {31'b0, write_en}, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_rdata", mem_read_data, 32'd0);
    @(posedge clk); #1;
    mem_r_en = 1'b0; rst_n = 1'b1;
    go_idle(2);

    // Posted store then drain
    do_instr(1'b0, 1'b1, 32'h400, 32'hDEADBEEF, st, rd);
    check("store_stalls", st, 32'd0);
    mem_w_en = 1'b0;
    @(negedge clk);
    check("pre_drain_we", {31'b0, write_en}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_we", {31'b0, write_en}, 32'd1);
    check("drain_addr", address, 32'h400);
    check("drain_wdata", write_data, 32'hDEADBEEF);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (write_en) n++;
      else break;
    end
    check("drain_cycles", n, 32'd6);
    go_idle(2);

    // Forwarding from the buffer
    do_instr(1'b0, 1'b1, 32'h404, 32'h12345678, st, rd);
    do_instr(1'b1, 1'b0, 32'h406, 32'h0, st, rd);
    check("fwd_stalls", st, 32'd0);
    check("fwd_data", rd, 32'h12345678);
    mem_r_en = 1'b0;
    @(negedge clk);
    check("fwd_no_read", {31'b0, read_en}, 32'd0);
    check("fwd_then_drain", {31'b0, write_en}, 32'd1);
    go_idle(10);

    // Load miss, empty buffer
    do_instr(1'b1, 1'b0, 32'h500, 32'h0, st, rd);
    check("miss_stalls", st, 32'd6);
    check("miss_data", rd, 32'hCAFEF00D);
    mem_r_en = 1'b0;
    @(negedge clk);
    check("rdata_hold", mem_read_data, 32'hCAFEF00D);
    go_idle(1);

    // Back-to-back stores
    do_instr(1'b0, 1'b1, 32'h800, 32'h1, st, rd);
    do_instr(1'b0, 1'b1, 32'h804, 32'h2, st, rd);
    check("b2b_stalls", st, 32'd6);
    mem_w_en = 1'b0;
    @(negedge clk);
    check("b2b_gap_we", {31'b0, write_en}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_we", {31'b0, write_en}, 32'd1);
    check("b2b_addr", address, 32'h804);
    check("b2b_wdata", write_data, 32'h2);
    go_idle(10);

    // Non-hit load behind a store
    do_instr(1'b0, 1'b1, 32'h600, 32'h66, st, rd);
    do_instr(1'b1, 1'b0, 32'h700, 32'h0, st, rd);
    check("order_stalls", st, 32'd13);
    check("order_data", rd, 32'h70707070);
    wa = 30'h180;
    check("order_store_landed", ctrl_word(wa), 32'h66);
    go_idle(2);

    // Reset in the middle of a read
    mem_r_en = 1'b1; mem_address = 32'h900;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("read_active", {31'b0, read_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_read_en", {31'b0, read_en}, 32'd0);
    check("arst_freeze", {31'b0, freeze}, 32'd0);
    check("arst_rdata", mem_read_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {31'b0, read_en}, 32'd0);
    check("post_rst_freeze", {31'b0, freeze}, 32'd1);
    @(posedge clk); #1;
    do_instr(1'b1, 1'b0, 32'h900, 32'h0, st, rd);
    go_idle(2);

    // Randomized traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      int kind;
      next_lat = $urandom_range(1, 5);
      kind = $urandom_range(0, 9);
      a = 32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      if (kind < 4)      do_instr(1'b1, 1'b0, a, $urandom, st, rd);
      else if (kind < 8) do_instr(1'b0, 1'b1, a, $urandom, st, rd);
      else if (kind == 8) do_instr(1'b1, 1'b1, a, $urandom, st, rd);
      else               do_instr(1'b0, 1'b0, a, $urandom, st, rd);
    end
    go_idle(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
